rx_frame_ctrl: RTL

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - receive frame controller: length tracking, limit checks, good/bad frame verdict
module rx_frame_ctrl #(
  parameter int DATA_BYTES = 8,
  parameter int MAX_LEN    = 1518,
  parameter int JUMBO_LEN  = 9018,
  parameter int MIN_LEN    = 64,
  parameter int CNT_W      = 14
) (
  input  logic                          rxclk,
  input  logic                          reset,
  input  logic                          recv_enable,
  input  logic                          jumbo_enable,
  input  logic                          get_sfd,
  input  logic                          beat_valid,
  input  logic [$clog2(DATA_BYTES):0]   beat_bytes,
  input  logic                          end_frame,
  input  logic                          local_invalid,
  input  logic                          tagged_frame,
  input  logic [15:0]                   len_type,
  input  logic                          get_error_code,
  input  logic                          crc_check_valid,
  input  logic                          crc_check_invalid,
  output logic                          receiving,
  output logic [CNT_W-1:0]              frame_len,
  output logic                          good_frame_get,
  output logic                          bad_frame_get,
  output logic [4:0]                    err_vec
);

  localparam int BB_W = $clog2(DATA_BYTES) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic [4:0]       err_vec_q, err_vec_d;
  logic             jumbo_q, jumbo_d;

  logic [CNT_W:0]   len_sum;
  logic [CNT_W-1:0] len_cur;
  logic [31:0]      limit;
  logic [31:0]      exp_len;
  logic             over;
  logic             len_err;
  logic             undersize;
  logic             good_c;
  logic             bad_c;

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    err_vec_d   = err_vec_q;
    jumbo_d     = jumbo_q;
    good_c      = 1'b0;
    bad_c       = 1'b0;

    len_sum = {1'b0, frame_len_q} + {{(CNT_W + 1 - BB_W){1'b0}}, beat_bytes};
    if (!beat_valid) begin
      len_cur = frame_len_q;
    end else if (len_sum[CNT_W]) begin
      len_cur = '1;
    end else begin
      len_cur = len_sum[CNT_W-1:0];
    end

    limit = (jumbo_q ? 32'(JUMBO_LEN) : 32'(MAX_LEN)) + (tagged_frame ? 32'd4 : 32'd0);
    over  = 32'(len_cur) > limit;

    // Expected on-wire size implied by a Length field, never below the minimum frame.
    exp_len = 32'(len_type) + 32'd18 + (tagged_frame ? 32'd4 : 32'd0);
    if (exp_len < 32'(MIN_LEN)) begin
      exp_len = 32'(MIN_LEN);
    end
    len_err   = (len_type < 16'd1536) && (32'(frame_len_q) != exp_len);
    undersize = 32'(frame_len_q) < 32'(MIN_LEN);

    case (state_q)
      S_IDLE: begin
        if (get_sfd && recv_enable) begin
          state_d     = S_HDR;
          frame_len_d = '0;
          err_vec_d   = '0;
          jumbo_d     = jumbo_enable;
        end
      end
      S_HDR, S_DATA: begin
        frame_len_d = len_cur;
        if (local_invalid || get_error_code || over) begin
          state_d   = S_DROP;
          err_vec_d = err_vec_q | {get_error_code, 3'b000, over};
          bad_c     = 1'b1;
        end else if (end_frame && (state_q == S_HDR || beat_valid)) begin
          state_d = S_CHECK;
        end else if (state_q == S_HDR && beat_valid && len_cur >= CNT_W'(14)) begin
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        if (crc_check_valid || crc_check_invalid) begin
          err_vec_d = err_vec_q | {1'b0, crc_check_invalid, len_err, undersize, 1'b0};
          good_c    = (err_vec_d == 5'd0);
          bad_c     = (err_vec_d != 5'd0);
          state_d   = S_IDLE;
        end
      end
      S_DROP: begin
        if (beat_valid && end_frame) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      frame_len_q <= '0;
      err_vec_q   <= '0;
      jumbo_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_len_q <= frame_len_d;
      err_vec_q   <= err_vec_d;
      jumbo_q     <= jumbo_d;
    end
  end

  assign receiving      = !reset && (state_q == S_HDR || state_q == S_DATA);
  assign good_frame_get = !reset && good_c;
  assign bad_frame_get  = !reset && bad_c;
  assign frame_len      = frame_len_q;
  assign err_vec        = err_vec_q;

endmodule
